// File: rtl/up_down_count_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : up_down_count_monitor_if
// Brief    : Observation bus between a 4-bit up/down counter and its monitor.
//            err_cnt exists only when MON_ERR_COUNT_EN is defined.
// Revision : 1.0
// ============================================================================
interface up_down_count_monitor_if #(
    parameter int WRAP_W = 8
);
    logic [3:0]        count;
    logic              up_down;
    logic              err_clr;
    logic              armed;
    logic              wrap_up;
    logic              wrap_dn;
    logic              err;
    logic              err_sticky;
    logic [WRAP_W-1:0] wrap_cnt;
`ifdef MON_ERR_COUNT_EN
    logic [7:0]        err_cnt;

    modport master (
        output count, up_down, err_clr,
        input  armed, wrap_up, wrap_dn, err, err_sticky, wrap_cnt, err_cnt
    );
    modport slave (
        input  count, up_down, err_clr,
        output armed, wrap_up, wrap_dn, err, err_sticky, wrap_cnt, err_cnt
    );
`else
    modport master (
        output count, up_down, err_clr,
        input  armed, wrap_up, wrap_dn, err, err_sticky, wrap_cnt
    );
    modport slave (
        input  count, up_down, err_clr,
        output armed, wrap_up, wrap_dn, err, err_sticky, wrap_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/up_down_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : up_down_count_monitor
// Brief    : Predicts the next legal count of a LOW..HIGH up/down counter and
//            flags mismatches, range errors and wrap events. MON_ERR_COUNT_EN
//            adds a saturating error counter.
// Revision : 1.0
// ============================================================================
module up_down_count_monitor #(
    parameter logic [3:0] LOW    = 4'd3,
    parameter logic [3:0] HIGH   = 4'd15,
    parameter int         WRAP_W = 8
) (
    input wire                      clk,
    input wire                      rst,
    up_down_count_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_check;
    logic [3:0]        r_c_q;
    logic              r_d_q;
    logic [3:0]        w_exp;
    logic [4:0]        w_lo_diff;
    logic [4:0]        w_hi_diff;
    logic              w_range_bad;
    logic              w_err;
    logic              w_wrap_up;
    logic              w_wrap_dn;
    logic              r_armed;
    logic              r_err;
    logic              r_wrap_up;
    logic              r_wrap_dn;
    logic              r_err_sticky;
    logic [WRAP_W-1:0] r_wrap_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_check     = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nxt = S_SYNC;
            S_SYNC: begin
                w_state_nxt = S_TRACK;
                w_check     = 1'b1;
            end
            S_TRACK: w_check = 1'b1;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_exp = r_d_q ? ((r_c_q == HIGH) ? LOW  : r_c_q + 4'd1)
                         : ((r_c_q == LOW)  ? HIGH : r_c_q - 4'd1);

    // Borrow bits give the range test without a constant-folded compare when HIGH is 15
    assign w_lo_diff   = {1'b0, bus.count} - {1'b0, LOW};
    assign w_hi_diff   = {1'b0, HIGH} - {1'b0, bus.count};
    assign w_range_bad = w_lo_diff[4] | w_hi_diff[4];

    assign w_err     = w_check & (w_range_bad | (bus.count != w_exp));
    assign w_wrap_up = w_check & ~w_err &  r_d_q & (r_c_q == LOW  ? 1'b0 : 1'b1) & (r_c_q == HIGH) & (bus.count == LOW);
    assign w_wrap_dn = w_check & ~w_err & ~r_d_q & (r_c_q == LOW) & (bus.count == HIGH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_c_q        <= LOW;
            r_d_q        <= 1'b1;
            r_armed      <= 1'b0;
            r_err        <= 1'b0;
            r_wrap_up    <= 1'b0;
            r_wrap_dn    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_wrap_cnt   <= '0;
        end else begin
            // Always resync to the observed value so one glitch yields one error
            r_c_q        <= bus.count;
            r_d_q        <= bus.up_down;
            r_armed      <= w_check;
            r_err        <= w_err;
            r_wrap_up    <= w_wrap_up;
            r_wrap_dn    <= w_wrap_dn;
            r_err_sticky <= w_err | (r_err_sticky & ~bus.err_clr);
            if ((w_wrap_up | w_wrap_dn) && (r_wrap_cnt != {WRAP_W{1'b1}})) begin
                r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
            end
        end
    end

    assign bus.armed      = r_armed;
    assign bus.err        = r_err;
    assign bus.wrap_up    = r_wrap_up;
    assign bus.wrap_dn    = r_wrap_dn;
    assign bus.err_sticky = r_err_sticky;
    assign bus.wrap_cnt   = r_wrap_cnt;

`ifdef MON_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_cnt <= 8'd0;
        end else if (bus.err_clr) begin
            r_err_cnt <= w_err ? 8'd1 : 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_up_down_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_down_count_monitor
// Brief    : Scoreboard bench for up_down_count_monitor (LOW=3, HIGH=15, WRAP_W=4).
// Revision : 1.0
// ============================================================================
module tb_up_down_count_monitor;

    localparam logic [3:0] LOW    = 4'd3;
    localparam logic [3:0] HIGH   = 4'd15;
    localparam int         WRAP_W = 4;

    typedef struct packed {
        logic              armed;
        logic              wu;
        logic              wd;
        logic              err;
        logic              sticky;
        logic [WRAP_W-1:0] wcnt;
        logic [7:0]        ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   obs_err = 0;
    int   obs_wu  = 0;
    int   obs_wd  = 0;

    exp_t sb[$];
    exp_t mon_e;

    int                m_phase;
    logic [3:0]        m_c;
    logic              m_d;
    logic              m_sticky;
    logic [WRAP_W-1:0] m_wcnt;
    logic [7:0]        m_ecnt;

    always #5 clk = ~clk;

    up_down_count_monitor_if #(.WRAP_W(WRAP_W)) bus ();

    up_down_count_monitor #(
        .LOW    (LOW),
        .HIGH   (HIGH),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard consumer: each edge's expected flags are popped and compared
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (bus.armed !== mon_e.armed) begin
                errors++; $display("FAIL armed t=%0t got %b exp %b", $time, bus.armed, mon_e.armed);
            end
            checks++;
            if (bus.err !== mon_e.err) begin
                errors++; $display("FAIL err t=%0t got %b exp %b", $time, bus.err, mon_e.err);
            end
            checks++;
            if (bus.wrap_up !== mon_e.wu) begin
                errors++; $display("FAIL wrap_up t=%0t got %b exp %b", $time, bus.wrap_up, mon_e.wu);
            end
            checks++;
            if (bus.wrap_dn !== mon_e.wd) begin
                errors++; $display("FAIL wrap_dn t=%0t got %b exp %b", $time, bus.wrap_dn, mon_e.wd);
            end
            checks++;
            if (bus.err_sticky !== mon_e.sticky) begin
                errors++; $display("FAIL err_sticky t=%0t got %b exp %b", $time, bus.err_sticky, mon_e.sticky);
            end
            checks++;
            if (bus.wrap_cnt !== mon_e.wcnt) begin
                errors++; $display("FAIL wrap_cnt t=%0t got %0d exp %0d", $time, bus.wrap_cnt, mon_e.wcnt);
            end
`ifdef MON_ERR_COUNT_EN
            checks++;
            if (bus.err_cnt !== mon_e.ecnt) begin
                errors++; $display("FAIL err_cnt t=%0t got %0d exp %0d", $time, bus.err_cnt, mon_e.ecnt);
            end
`endif
            if (bus.err === 1'b1)     obs_err++;
            if (bus.wrap_up === 1'b1) obs_wu++;
            if (bus.wrap_dn === 1'b1) obs_wd++;
        end
    end

    // Drive one sample, push the reference expectation, wait for it to be judged
    task automatic step(input logic [3:0] cnt, input logic ud, input logic clr, input logic rn);
        exp_t       e;
        logic [3:0] ex;
        logic       er;
        @(negedge clk);
        bus.count   = cnt;
        bus.up_down = ud;
        bus.err_clr = clr;
        rst         = rn;
        e  = '0;
        er = 1'b0;
        if (!rn) begin
            m_phase  = 0;
            m_c      = LOW;
            m_d      = 1'b1;
            m_sticky = 1'b0;
            m_wcnt   = '0;
            m_ecnt   = 8'd0;
        end else begin
            if (m_phase != 0) begin
                if (m_d) ex = (m_c == HIGH) ? LOW : 4'(m_c + 4'd1);
                else     ex = (m_c == LOW) ? HIGH : 4'(m_c - 4'd1);
                er = (int'(cnt) < int'(LOW)) || (int'(cnt) > int'(HIGH)) || (cnt != ex);
                e.armed = 1'b1;
                e.err   = er;
                e.wu    = !er && m_d && (m_c == HIGH) && (cnt == LOW);
                e.wd    = !er && !m_d && (m_c == LOW) && (cnt == HIGH);
                if ((e.wu || e.wd) && (m_wcnt != {WRAP_W{1'b1}})) m_wcnt = m_wcnt + 1'b1;
            end
            m_sticky = er | (m_sticky & ~clr);
            if (clr)                        m_ecnt = er ? 8'd1 : 8'd0;
            else if (er && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            m_phase = (m_phase == 0) ? 1 : 2;
            m_c     = cnt;
            m_d     = ud;
        end
        e.sticky = m_sticky;
        e.wcnt   = m_wcnt;
        e.ecnt   = m_ecnt;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(LOW, 1'b1, 1'b0, 1'b0);
        obs_err = 0;
        obs_wu  = 0;
        obs_wd  = 0;
    endtask

    task automatic test_reset();
        step(4'd0, 1'b1, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.armed !== 1'b0 || bus.err_sticky !== 1'b0 || bus.wrap_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state got armed=%b sticky=%b wcnt=%0d exp 0/0/0",
                     bus.armed, bus.err_sticky, bus.wrap_cnt);
        end
    endtask

    task automatic test_count_up();
        do_reset();
        for (int v = 3; v <= 15; v++) step(4'(v), 1'b1, 1'b0, 1'b1);
        step(LOW, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_wu !== 1 || obs_wd !== 0 || obs_err !== 0 || bus.wrap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL count_up got wu=%0d wd=%0d err=%0d wcnt=%0d exp 1/0/0/1",
                     obs_wu, obs_wd, obs_err, bus.wrap_cnt);
        end
    endtask

    task automatic test_count_down();
        do_reset();
        for (int v = 15; v >= 3; v--) step(4'(v), 1'b0, 1'b0, 1'b1);
        step(HIGH, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_wd !== 1 || obs_wu !== 0 || obs_err !== 0 || bus.wrap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL count_down got wd=%0d wu=%0d err=%0d wcnt=%0d exp 1/0/0/1",
                     obs_wd, obs_wu, obs_err, bus.wrap_cnt);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        step(4'd5,  1'b1, 1'b0, 1'b1);
        step(4'd6,  1'b1, 1'b0, 1'b1);
        step(4'd9,  1'b1, 1'b0, 1'b1);
        step(4'd10, 1'b1, 1'b0, 1'b1);
        step(4'd11, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_err !== 1 || bus.err_sticky !== 1'b1 || (obs_wu + obs_wd) !== 0) begin
            errors++;
            $display("FAIL glitch got errs=%0d sticky=%b wraps=%0d exp 1/1/0",
                     obs_err, bus.err_sticky, obs_wu + obs_wd);
        end
    endtask

    task automatic test_range_and_clear();
        do_reset();
        step(4'd5, 1'b1, 1'b0, 1'b1);
        step(4'd6, 1'b1, 1'b0, 1'b1);
        step(4'd2, 1'b0, 1'b0, 1'b1);   // mismatch and below LOW
        step(4'd1, 1'b1, 1'b0, 1'b1);   // predicted exactly, but below LOW
        step(4'd2, 1'b1, 1'b0, 1'b1);
        step(4'd3, 1'b1, 1'b0, 1'b1);
        step(4'd4, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.err_sticky !== 1'b0 || obs_err !== 3) begin
            errors++;
            $display("FAIL err_clr got sticky=%b errs=%0d exp 0/3", bus.err_sticky, obs_err);
        end
`ifdef MON_ERR_COUNT_EN
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL err_cnt_clr got %0d exp 0", bus.err_cnt);
        end
`endif
        step(4'd9,  1'b1, 1'b1, 1'b1);  // error and clear on the same edge
        step(4'd10, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.err_sticky !== 1'b1 || obs_err !== 4) begin
            errors++;
            $display("FAIL err_and_clr got sticky=%b errs=%0d exp 1/4", bus.err_sticky, obs_err);
        end
`ifdef MON_ERR_COUNT_EN
        checks++;
        if (bus.err_cnt !== 8'd1) begin
            errors++; $display("FAIL err_cnt_same_edge got %0d exp 1", bus.err_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'd14, 1'b1, 1'b0, 1'b1);
        step(4'd15, 1'b1, 1'b0, 1'b1);
        step(4'd3,  1'b1, 1'b0, 1'b1);
        step(4'd4,  1'b1, 1'b0, 1'b1);
        step(4'd7,  1'b1, 1'b0, 1'b1);
        step(4'd9,  1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.armed !== 1'b0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b0 ||
            bus.wrap_up !== 1'b0 || bus.wrap_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid got armed=%b err=%b sticky=%b wu=%b wcnt=%0d exp all 0",
                     bus.armed, bus.err, bus.err_sticky, bus.wrap_up, bus.wrap_cnt);
        end
        obs_err = 0;
        step(4'd12, 1'b1, 1'b0, 1'b1);
        step(4'd13, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_err !== 0 || bus.armed !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got errs=%0d armed=%b exp 0/1", obs_err, bus.armed);
        end
    endtask

    task automatic test_saturate_and_flip();
        do_reset();
        for (int n = 0; n < 25; n++) begin
            for (int v = 3; v <= 15; v++) step(4'(v), 1'b1, 1'b0, 1'b1);
        end
        step(LOW, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_wu !== 25 || bus.wrap_cnt !== 4'd15 || obs_err !== 0) begin
            errors++;
            $display("FAIL wrap_saturate got wu=%0d wcnt=%0d errs=%0d exp 25/15/0",
                     obs_wu, bus.wrap_cnt, obs_err);
        end
        step(4'd4, 1'b1, 1'b0, 1'b1);
        step(4'd5, 1'b1, 1'b0, 1'b1);
        step(4'd6, 1'b1, 1'b0, 1'b1);
        step(4'd7, 1'b1, 1'b0, 1'b1);
        step(4'd8, 1'b0, 1'b0, 1'b1);
        step(4'd7, 1'b0, 1'b0, 1'b1);
        step(4'd6, 1'b1, 1'b0, 1'b1);
        step(4'd7, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_err !== 0 || bus.wrap_cnt !== 4'd15) begin
            errors++;
            $display("FAIL dir_flip got errs=%0d wcnt=%0d exp 0/15", obs_err, bus.wrap_cnt);
        end
    endtask

    initial begin
        rst         = 1'b0;
        bus.count   = 4'd0;
        bus.up_down = 1'b1;
        bus.err_clr = 1'b0;
        m_phase     = 0;
        m_c         = LOW;
        m_d         = 1'b1;
        m_sticky    = 1'b0;
        m_wcnt      = '0;
        m_ecnt      = 8'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_glitch();
        test_range_and_clear();
        test_reset_mid();
        test_saturate_and_flip();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
